// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the core's data-memory port.
// TXDATA (BASE+0) queues bytes into a small FIFO; STATUS (BASE+4) reports
// full/empty/busy/ovf/count. Reads are combinational; tx is registered.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic [BW-1:0]  baud, baud_nx;
    logic [2:0]     bit_idx, bit_nx;
    logic [7:0]     shift, shift_nx;
    logic           tx_nx;
    logic           baud_wrap;
    logic           pop;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic           fifo_empty, fifo_full;
    logic           ovf;

    logic           sel_status, wr_tx, wr_st, push;
    logic [31:0]    status;
    logic           unused_bits;

    assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

    assign Hit        = (ALUResult[31:3] == BASE_ADDR[31:3]);
    assign sel_status = ALUResult[2];
    assign wr_tx      = Hit & MemWrite & ~sel_status;
    assign wr_st      = Hit & MemWrite & sel_status;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    // A pop on the same edge frees the slot the push is about to use.
    assign push       = wr_tx & (~fifo_full | pop);
    assign baud_wrap  = (baud == BW'(CLKS_PER_BIT - 1));

    assign status = {16'h0, 8'(count), 4'h0, ovf, (state != IDLE), fifo_empty, fifo_full};

    // Register read mux; TXDATA and misses read as zero.
    always_comb begin
        ReadData = '0;
        if (Hit && sel_status)
            ReadData = status;
    end

    // FIFO storage: byte lands at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= WriteData[7:0];
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            // Setting on a dropped byte takes priority over a clear.
            if (wr_tx && !push)
                ovf <= 1'b1;
            else if (wr_st && WriteData[3])
                ovf <= 1'b0;
        end
    end

    // Transmit state, baud counter, bit index and the registered line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_nx;
            tx      <= tx_nx;
        end
    end

    // Shift register holds the frame byte; contents are don't-care when idle.
    always_ff @(posedge clk) begin
        shift <= shift_nx;
    end

    // Next-state logic; tx_nx is the level the line takes after this edge.
    always_comb begin
        state_nx = state;
        baud_nx  = baud;
        bit_nx   = bit_idx;
        shift_nx = shift;
        tx_nx    = tx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[rptr];
                    baud_nx  = '0;
                    bit_nx   = '0;
                    tx_nx    = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_nx  = '0;
                    tx_nx    = shift[0];
                    state_nx = DATA;
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_nx  = '0;
                    shift_nx = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 1'b1;
                        tx_nx  = shift[1];
                    end
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_nx = '0;
                    bit_nx  = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[rptr];
                        tx_nx    = 1'b0;
                        state_nx = START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized self-checking bench for mmio_uart_tx with a frame-level model.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .tx(tx)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue plus the position inside the current frame.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_pos;
    logic [7:0] m_cur;
    bit         m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        if (!m_active)       return 1'b1;
        if (m_pos < CPB)     return 1'b0;
        if (m_pos >= 9*CPB)  return 1'b1;
        return m_cur[m_pos/CPB - 1];
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        return a[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] model_status();
        return {16'h0, 8'(mq.size()), 4'h0, m_ovf, m_active,
                mq.size() == 0, mq.size() == DEPTH};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!model_hit(a) || !a[2]) return 32'h0;
        return model_status();
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovf    = 0;
    endtask

    task automatic model_edge();
        bit pop, wr_tx, wr_st, accept;
        pop    = (mq.size() != 0) && (!m_active || m_pos == FRAME-1);
        wr_tx  = MemWrite && model_hit(ALUResult) && !ALUResult[2];
        wr_st  = MemWrite && model_hit(ALUResult) && ALUResult[2];
        accept = wr_tx && (mq.size() < DEPTH || pop);
        if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 0;
        end
        if (pop) begin
            m_cur    = mq.pop_front();
            m_pos    = 0;
            m_active = 1;
        end
        if (accept) mq.push_back(WriteData[7:0]);
        if (wr_tx && !accept)               m_ovf = 1;
        else if (wr_st && WriteData[3])     m_ovf = 0;
    endtask

    // One clock: update the model at the edge, check the line at the falling edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        chk("tx", 32'(tx), 32'(model_tx()));
    endtask

    // Apply a bus cycle, check the combinational read side, then clock it.
    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite  = we;
        ALUResult = a;
        WriteData = d;
        #1;
        chk("hit", 32'(Hit), 32'(model_hit(a)));
        chk("rdata", ReadData, model_rd(a));
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, BASE + 4, 32'h0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_rd", ReadData, model_rd(ALUResult));
        step();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        step();
        step();
        reset = 1'b0;

        // Reset state.
        bus(1'b0, BASE + 4, 32'h0);
        chk("rst_status", ReadData, 32'h0000_0002);
        chk("rst_hit", 32'(Hit), 32'd1);
        chk("rst_line", 32'(tx), 32'd1);
        MemWrite = 1'b0; ALUResult = BASE; #1;
        chk("txdata_read", ReadData, 32'h0);
        step();

        // Single frame of 0x55.
        bus(1'b1, BASE, 32'h0000_AB55);
        idle(42);
        MemWrite = 1'b0; ALUResult = BASE + 4; #1;
        chk("frame_done", ReadData, 32'h0000_0002);
        step();

        // Six back-to-back writes overflow a four-deep FIFO.
        for (int b = 1; b <= 6; b++) bus(1'b1, BASE, 32'(b));
        MemWrite = 1'b0; ALUResult = BASE + 4; #1;
        chk("ovf_status", ReadData, 32'h0000_040D);
        step();

        // ovf clear semantics.
        bus(1'b1, BASE + 4, 32'h0);
        MemWrite = 1'b0; #1;
        chk("ovf_keep", 32'(ReadData[3]), 32'd1);
        step();
        bus(1'b1, BASE + 4, 32'h8);
        MemWrite = 1'b0; #1;
        chk("ovf_clear", 32'(ReadData[3]), 32'd0);
        step();
        idle(5 * FRAME);
        MemWrite = 1'b0; ALUResult = BASE + 4; #1;
        chk("drained", ReadData, 32'h0000_0002);
        step();

        // Reset during data bit 3 with two bytes still queued.
        bus(1'b1, BASE, 32'hA5);
        bus(1'b1, BASE, 32'h3C);
        bus(1'b1, BASE, 32'hC3);
        idle(16);
        chk("in_bit3", 32'(m_active && m_pos / CPB == 4), 32'd1);
        MemWrite = 1'b0; ALUResult = BASE + 4;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            bus(1'b0, BASE + 4, 32'h0);
            chk("hold_tx", 32'(tx), 32'd1);
        end
        chk("post_rst_status", ReadData, 32'h0000_0002);

        // Writes outside the window.
        bus(1'b1, BASE + 8, 32'h77);
        bus(1'b1, 32'h0000_0040, 32'h77);
        idle(3);
        chk("miss_status", ReadData, 32'h0000_0002);
        chk("miss_tx", 32'(tx), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 80)
                bus(1'b1, BASE | ($urandom & 32'h3), $urandom);
            else if (r < 110)
                bus(1'b1, BASE | 32'h4 | ($urandom & 32'h3), $urandom);
            else if (r < 140)
                bus(1'b1, (r < 125) ? (BASE + 8 + ($urandom & 32'hFF)) : $urandom, $urandom);
            else if (r < 143)
                do_reset();
            else
                bus(1'b0, (r < 600) ? (BASE | ($urandom & 32'h7)) : $urandom, $urandom);
        end
        idle(6 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
